// File: rtl/column_slice_drawer.sv
// Draws one vertical column of the raycast view: clamps and centres the projected
// wall height, then plots ceiling / wall / floor colours one row per cycle.
module column_slice_drawer #(
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter logic [2:0]  CEIL_COLOUR  = 3'b000,
    parameter logic [2:0]  FLOOR_COLOUR = 3'b010
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_column,
    input  logic signed [20:0] in_height,
    input  logic [2:0]         in_colour,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [2:0]         colour,
    output logic               plot,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, CALC, DRAW, DONE} state_t;

    localparam logic [7:0]         SCREEN_W8  = 8'(SCREEN_W);
    localparam logic [7:0]         SCREEN_H8  = 8'(SCREEN_H);
    localparam logic signed [20:0] SCREEN_H_S = 21'(SCREEN_H);
    localparam logic [7:0]         LAST_ROW   = 8'(SCREEN_H - 1);

    state_t             state_r;
    logic [7:0]         column_r;
    logic signed [20:0] height_r;
    logic [2:0]         wall_colour_r;
    logic [7:0]         top_r;
    logic [7:0]         bottom_r;
    logic [7:0]         row_r;

    logic [7:0]         h_s;
    logic [7:0]         top_s;
    logic [7:0]         bottom_s;
    logic [7:0]         row_next_s;

    function automatic logic [2:0] row_colour(input logic [7:0] row,
                                              input logic [7:0] top,
                                              input logic [7:0] bottom,
                                              input logic [2:0] wall);
        if (row < top) begin
            return CEIL_COLOUR;
        end else if (row <= bottom) begin
            return wall;
        end else begin
            return FLOOR_COLOUR;
        end
    endfunction

    // Clamp the latched height and derive the centred wall span.
    always_comb begin
        h_s = 8'd0;
        if (height_r < 21'sd0) begin
            h_s = 8'd0;
        end else if (height_r > SCREEN_H_S) begin
            h_s = SCREEN_H8;
        end else begin
            h_s = height_r[7:0];
        end
        // h = 0 gives bottom = top - 1, i.e. an empty wall span.
        top_s      = (SCREEN_H8 - h_s) >> 1'b1;
        bottom_s   = top_s + h_s - 8'd1;
        row_next_s = row_r + 8'd1;
    end

    // Control FSM with registered plot outputs; row 0 is issued from CALC.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            in_ready      <= 1'b1;
            plot          <= 1'b0;
            done          <= 1'b0;
            x             <= 8'd0;
            y             <= 7'd0;
            colour        <= 3'd0;
            row_r         <= 8'd0;
            column_r      <= 8'd0;
            height_r      <= 21'sd0;
            wall_colour_r <= 3'd0;
            top_r         <= 8'd0;
            bottom_r      <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (in_valid) begin
                        column_r      <= in_column;
                        height_r      <= in_height;
                        wall_colour_r <= in_colour;
                        in_ready      <= 1'b0;
                        state_r       <= CALC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    top_r    <= top_s;
                    bottom_r <= bottom_s;
                    if (column_r >= SCREEN_W8) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        row_r   <= 8'd0;
                        x       <= column_r;
                        y       <= 7'd0;
                        colour  <= row_colour(8'd0, top_s, bottom_s, wall_colour_r);
                        plot    <= 1'b1;
                        state_r <= DRAW;
                    end
                end
                DRAW: begin
                    if (row_r == LAST_ROW) begin
                        plot    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        row_r  <= row_next_s;
                        y      <= row_next_s[6:0];
                        colour <= row_colour(row_next_s, top_r, bottom_r, wall_colour_r);
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    plot     <= 1'b0;
                    in_ready <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    done     <= 1'b0;
                    plot     <= 1'b0;
                    in_ready <= 1'b1;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_column_slice_drawer.sv
// Bench for column_slice_drawer: table of column requests, scoreboard of expected
// pixels/done pulses with cycle stamps, plus reset and busy-period sequences.
module tb_column_slice_drawer;

    localparam logic [2:0] CEIL  = 3'b000;
    localparam logic [2:0] FLOOR = 3'b010;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_column;
    logic signed [20:0] in_height;
    logic [2:0]         in_colour;
    logic [7:0]         x;
    logic [6:0]         y;
    logic [2:0]         colour;
    logic               plot;
    logic               done;

    column_slice_drawer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_column(in_column), .in_height(in_height), .in_colour(in_colour),
        .x(x), .y(y), .colour(colour), .plot(plot), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]         col;
        logic signed [20:0] h;
        logic [2:0]         c;
        int                 wf;
        int                 wl;
        bit                 draws;
    } vec_t;

    typedef struct {
        logic [17:0] pix;
        int          cyc;
    } pix_t;

    vec_t  vecs [15];
    pix_t  pix_q [$];
    int    done_q [$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    accept_cyc = -1;
    int    ready_at = 0;
    bit    mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a request, wait for acceptance, then push the expected pixels and done.
    task automatic send(input logic [7:0] col, input logic signed [20:0] h, input logic [2:0] c,
                        input int wf, input int wl, input bit keep, output int acc);
        int waited = 0;
        logic [2:0] ec;
        @(negedge clock);
        in_valid = 1'b1; in_column = col; in_height = h; in_colour = c;
        while (!in_ready && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clock);
        #1;
        acc = cyc;
        accept_cyc = acc;
        if (!keep) begin
            in_valid  = 1'b0;
            in_column = 8'($urandom);
            in_height = 21'($urandom);
            in_colour = 3'($urandom);
        end
        if (col >= 8'd160) begin
            done_q.push_back(acc + 1);
            ready_at = acc + 2;
        end else begin
            for (int i = 0; i < 120; i++) begin
                if (i < wf) ec = CEIL;
                else if (i <= wl) ec = c;
                else ec = FLOOR;
                pix_q.push_back('{pix: {col, 7'(i), ec}, cyc: acc + 1 + i});
            end
            done_q.push_back(acc + 121);
            ready_at = acc + 122;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pix_q.size() != 0 || done_q.size() != 0) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 32'(pix_q.size() + done_q.size()), 32'd0);
        @(negedge clock);
    endtask

    // Scoreboard monitor: pixels, done pulses and in_ready during busy periods.
    always @(negedge clock) begin : monitor
        pix_t p;
        int   d;
        if (mon_en) begin
            if (plot) begin
                if (pix_q.size() == 0) begin
                    chk("unexpected_plot", {14'd0, x, y, colour}, 32'd0);
                end else begin
                    p = pix_q.pop_front();
                    chk("pixel_xyc", {14'd0, x, y, colour}, {14'd0, p.pix});
                    chk("pixel_cycle", 32'(cyc), 32'(p.cyc));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(cyc), 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d));
                end
            end
            if (cyc > accept_cyc && cyc < ready_at) chk("busy_ready_low", {31'd0, in_ready}, 32'd0);
            if (cyc == ready_at) chk("ready_return", {31'd0, in_ready}, 32'd1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a;
        vecs[0]  = '{8'd5,   21'sd40,      3'b100, 40, 79,  1'b1};
        vecs[1]  = '{8'd17,  21'sd51,      3'b011, 34, 84,  1'b1};
        vecs[2]  = '{8'd80,  21'sd200,     3'b101, 0,  119, 1'b1};
        vecs[3]  = '{8'd33,  -21'sd7,      3'b110, 60, 59,  1'b1};
        vecs[4]  = '{8'd34,  21'sd0,       3'b001, 60, 59,  1'b1};
        vecs[5]  = '{8'd100, 21'sd120,     3'b111, 0,  119, 1'b1};
        vecs[6]  = '{8'd101, 21'sd121,     3'b100, 0,  119, 1'b1};
        vecs[7]  = '{8'd102, 21'sd1,       3'b011, 59, 59,  1'b1};
        vecs[8]  = '{8'd103, 21'sd119,     3'b101, 0,  118, 1'b1};
        vecs[9]  = '{8'd159, 21'sd2,       3'b110, 59, 60,  1'b1};
        vecs[10] = '{8'd110, 21'sh100000,  3'b111, 60, 59,  1'b1};
        vecs[11] = '{8'd111, 21'sd1048575, 3'b001, 0,  119, 1'b1};
        vecs[12] = '{8'd160, 21'sd40,      3'b100, 0,  0,   1'b0};
        vecs[13] = '{8'd255, 21'sd200,     3'b111, 0,  0,   1'b0};
        vecs[14] = '{8'd60,  21'sd118,     3'b010, 1,  118, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_column = 8'd0; in_height = 21'sd0; in_colour = 3'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_ready", {31'd0, in_ready}, 32'd1);
            chk("idle_plot_done", {30'd0, plot, done}, 32'd0);
            chk("idle_xyc", {14'd0, x, y, colour}, 32'd0);
        end
        mon_en = 1'b1;

        for (int i = 0; i < 15; i++) begin
            send(vecs[i].col, vecs[i].h, vecs[i].c, vecs[i].wf, vecs[i].wl, 1'b0, a);
            wait_idle();
            if (vecs[i].draws) begin
                chk("hold_xy", {17'd0, x, y}, {17'd0, vecs[i].col, 7'd119});
                chk("hold_colour", {29'd0, colour}, {29'd0, (vecs[i].wl >= 119) ? vecs[i].c : FLOOR});
            end
        end

        // Request held high across three columns.
        send(8'd0, 21'sd40, 3'b001, 40, 79, 1'b1, a0);
        send(8'd1, 21'sd51, 3'b100, 34, 84, 1'b1, a1);
        send(8'd2, 21'sd0,  3'b111, 60, 59, 1'b0, a2);
        chk("b2b_period_1", 32'(a1 - a0), 32'd123);
        chk("b2b_period_2", 32'(a2 - a1), 32'd123);
        wait_idle();

        // Reset while row 50 is on the plot port.
        send(8'd3, 21'sd40, 3'b100, 40, 79, 1'b0, a);
        while (cyc < a + 51) @(negedge clock);
        #1;
        chk("pre_reset_row", {25'd0, y}, 32'd50);
        reset = 1'b1;
        pix_q.delete();
        done_q.delete();
        ready_at = 0;
        @(posedge clock);
        @(negedge clock);
        chk("reset_plot_low", {30'd0, plot, done}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_xyc", {14'd0, x, y, colour}, 32'd0);
        reset = 1'b0;
        send(8'd7, 21'sd60, 3'b101, 30, 89, 1'b0, a);
        wait_idle();

        // Stray valid pulses during DRAW must be ignored.
        send(8'd9, 21'sd30, 3'b111, 45, 74, 1'b0, a);
        while (cyc < a + 20) @(negedge clock);
        in_valid = 1'b1; in_column = 8'd20; in_height = 21'sd50;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clock);
        chk("no_extra_column", 32'(pix_q.size() + done_q.size()), 32'd0);
        chk("final_idle_ready", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
